// File: rtl/alu_station.sv
// alu_station -- single-entry reservation station in front of one integer ALU.
//
// Accepts one issued ALU operation from the allocator. Each operand arrives
// either as data or as a producer tag. The station watches the three
// register write-back ports until every tag is cleared, then executes the
// operation and presents a one-cycle write-back.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rdy                 global enable; low freezes all state and outputs
//   flush               discard the entry (branch mispredict)
//   en_in, op_in        issue strobe and operation code
//   tag{x,y,w}_in       source/destination tags (0 = operand valid)
//   data{x,y}_in        operand values, meaningful when the tag is 0
//   addr{x,y,w}_in      source/destination register numbers
//   en_mwK, reg_write_addrK, write_dataK   write-back ports 0..2 (snooped)
//   busy_out            entry occupied (feeds allocator issue throttle)
//   wb_en_out, wb_addr_out, wb_data_out     registered result write-back
module alu_station #(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             en_in,
  input  logic [3:0]       op_in,
  input  logic [TAG_W-1:0] tagx_in,
  input  logic [TAG_W-1:0] tagy_in,
  input  logic [TAG_W-1:0] tagw_in,
  input  logic [31:0]      datax_in,
  input  logic [31:0]      datay_in,
  input  logic [4:0]       addrx_in,
  input  logic [4:0]       addry_in,
  input  logic [4:0]       addrw_in,
  input  logic             en_mw0,
  input  logic             en_mw1,
  input  logic             en_mw2,
  input  logic [4:0]       reg_write_addr0,
  input  logic [4:0]       reg_write_addr1,
  input  logic [4:0]       reg_write_addr2,
  input  logic [31:0]      write_data0,
  input  logic [31:0]      write_data1,
  input  logic [31:0]      write_data2,
  output logic             busy_out,
  output logic             wb_en_out,
  output logic [4:0]       wb_addr_out,
  output logic [31:0]      wb_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam logic [TAG_W-1:0] TAG_CLEAR = {TAG_W{1'b0}};

  // Bit k set when write-back port k targets the given register. Register 0
  // is never locked, so it can never match.
  function automatic logic [2:0] match_vec(
    input logic [2:0]      en,
    input logic [2:0][4:0] waddr,
    input logic [4:0]      addr
  );
    logic [2:0] m;
    for (int k = 0; k < 3; k++) begin
      m[k] = en[k] && (waddr[k] == addr) && (addr != 5'd0);
    end
    return m;
  endfunction

  // Lowest-numbered matching port supplies the data.
  function automatic logic [31:0] pick_data(
    input logic [2:0]       m,
    input logic [2:0][31:0] wdata
  );
    logic [31:0] d;
    if (m[0]) begin
      d = wdata[0];
    end else if (m[1]) begin
      d = wdata[1];
    end else begin
      d = wdata[2];
    end
    return d;
  endfunction

  // Integer operation; unused op codes yield 0.
  function automatic logic [31:0] alu_compute(
    input logic [3:0]  op,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [31:0] r;
    case (op)
      4'd0:    r = x + y;
      4'd1:    r = x - y;
      4'd2:    r = x << y[4:0];
      4'd3:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4:    r = (x < y) ? 32'd1 : 32'd0;
      4'd5:    r = x ^ y;
      4'd6:    r = x >> y[4:0];
      4'd7:    r = $unsigned($signed(x) >>> y[4:0]);
      4'd8:    r = x | y;
      4'd9:    r = x & y;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_t           state_r;
  logic             busy_r;
  logic             wb_en_r;
  logic [4:0]       wb_addr_r;
  logic [31:0]      wb_data_r;
  logic [3:0]       op_r;
  logic [4:0]       addrx_r, addry_r, addrw_r;
  logic [TAG_W-1:0] tagx_r, tagy_r, tagw_r;
  logic [31:0]      datax_r, datay_r;

  logic [2:0]       en_mw_s;
  logic [2:0][4:0]  wr_addr_s;
  logic [2:0][31:0] wr_data_s;
  logic [4:0]       cur_addrx_s, cur_addry_s, cur_addrw_s;
  logic [TAG_W-1:0] cur_tagx_s, cur_tagy_s, cur_tagw_s;
  logic [31:0]      cur_datax_s, cur_datay_s;
  logic [2:0]       mx_s, my_s, mw_s;
  logic [TAG_W-1:0] snp_tagx_s, snp_tagy_s, snp_tagw_s;
  logic [31:0]      snp_datax_s, snp_datay_s;
  logic             all_clear_s;
  logic [31:0]      alu_result_s;

  assign en_mw_s   = {en_mw2, en_mw1, en_mw0};
  assign wr_addr_s = {reg_write_addr2, reg_write_addr1, reg_write_addr0};
  assign wr_data_s = {write_data2, write_data1, write_data0};

  // Snoop source: the issue inputs while capturing in IDLE, the held entry otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_addrx_s = addrx_in;
      cur_addry_s = addry_in;
      cur_addrw_s = addrw_in;
      cur_tagx_s  = tagx_in;
      cur_tagy_s  = tagy_in;
      cur_tagw_s  = tagw_in;
      cur_datax_s = datax_in;
      cur_datay_s = datay_in;
    end else begin
      cur_addrx_s = addrx_r;
      cur_addry_s = addry_r;
      cur_addrw_s = addrw_r;
      cur_tagx_s  = tagx_r;
      cur_tagy_s  = tagy_r;
      cur_tagw_s  = tagw_r;
      cur_datax_s = datax_r;
      cur_datay_s = datay_r;
    end
  end

  assign mx_s = match_vec(en_mw_s, wr_addr_s, cur_addrx_s);
  assign my_s = match_vec(en_mw_s, wr_addr_s, cur_addry_s);
  assign mw_s = match_vec(en_mw_s, wr_addr_s, cur_addrw_s);

  // Resolve operand x: only a still-tagged operand takes write-back data.
  always_comb begin
    snp_tagx_s  = cur_tagx_s;
    snp_datax_s = cur_datax_s;
    if ((cur_tagx_s != TAG_CLEAR) && (mx_s != 3'b000)) begin
      snp_tagx_s  = TAG_CLEAR;
      snp_datax_s = pick_data(mx_s, wr_data_s);
    end else begin
      snp_tagx_s  = cur_tagx_s;
      snp_datax_s = cur_datax_s;
    end
  end

  // Resolve operand y, same rule as x.
  always_comb begin
    snp_tagy_s  = cur_tagy_s;
    snp_datay_s = cur_datay_s;
    if ((cur_tagy_s != TAG_CLEAR) && (my_s != 3'b000)) begin
      snp_tagy_s  = TAG_CLEAR;
      snp_datay_s = pick_data(my_s, wr_data_s);
    end else begin
      snp_tagy_s  = cur_tagy_s;
      snp_datay_s = cur_datay_s;
    end
  end

  // Destination tag clears when an older write to the same register retires.
  always_comb begin
    snp_tagw_s = cur_tagw_s;
    if ((cur_tagw_s != TAG_CLEAR) && (mw_s != 3'b000)) begin
      snp_tagw_s = TAG_CLEAR;
    end else begin
      snp_tagw_s = cur_tagw_s;
    end
  end

  assign all_clear_s  = (snp_tagx_s == TAG_CLEAR) && (snp_tagy_s == TAG_CLEAR) &&
                        (snp_tagw_s == TAG_CLEAR);
  assign alu_result_s = alu_compute(op_r, datax_r, datay_r);

  // Station FSM: capture, operand wakeup, execute and write-back registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      wb_en_r   <= 1'b0;
      wb_addr_r <= 5'd0;
      wb_data_r <= 32'd0;
      op_r      <= 4'd0;
      addrx_r   <= 5'd0;
      addry_r   <= 5'd0;
      addrw_r   <= 5'd0;
      tagx_r    <= TAG_CLEAR;
      tagy_r    <= TAG_CLEAR;
      tagw_r    <= TAG_CLEAR;
      datax_r   <= 32'd0;
      datay_r   <= 32'd0;
    end else if (rdy) begin
      if (flush) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
        wb_en_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (en_in) begin
              op_r    <= op_in;
              addrx_r <= addrx_in;
              addry_r <= addry_in;
              addrw_r <= addrw_in;
              tagx_r  <= snp_tagx_s;
              tagy_r  <= snp_tagy_s;
              tagw_r  <= snp_tagw_s;
              datax_r <= snp_datax_s;
              datay_r <= snp_datay_s;
              busy_r  <= 1'b1;
              state_r <= all_clear_s ? ST_EXEC : ST_WAIT;
            end
          end
          ST_WAIT: begin
            tagx_r  <= snp_tagx_s;
            tagy_r  <= snp_tagy_s;
            tagw_r  <= snp_tagw_s;
            datax_r <= snp_datax_s;
            datay_r <= snp_datay_s;
            if (all_clear_s) begin
              state_r <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            wb_data_r <= alu_result_s;
            wb_addr_r <= addrw_r;
            wb_en_r   <= (addrw_r != 5'd0);
            state_r   <= ST_WB;
          end
          ST_WB: begin
            wb_en_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: begin
            wb_en_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy_out    = busy_r;
  assign wb_en_out   = wb_en_r;
  assign wb_addr_out = wb_addr_r;
  assign wb_data_out = wb_data_r;

endmodule
